csr_file: RTL and testbench
===========================

// Module: csr_file
// PURPOSE
//  Machine-mode CSR register file: the responder side of csr_if (csr modport), driven by decode/execute.
//  Performs CSRRW/RS/RC and immediate variants with read-old/write-new semantics.
//  Holds trap state (mepc/mcause/mtval/mstatus) and 64-bit cycle/instret counters; exports mtvec/mepc to fetch.
// PARAMETERS
//  HART_ID   0             value returned by mhartid (0xF14)
//  MISA_VAL  32'h40001101  value returned by misa (0x301): RV32, I+M+A
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, synchronous, active-high
//  csr_index    in   12  csr_cmd.index
//  csr_opcode   in   3   csr_cmd.opcode (system_funct3_t)
//  csr_valid    in   1   csr_cmd.valid: current instruction is a CSR instruction
//  csr_ren      in   1   csr_cmd.ren
//  csr_wen      in   1   csr_cmd.wen
//  csr_reg_val  in   32  csr_input.reg_val (rs1 value)
//  csr_uimm     in   5   csr_input.uimm
//  csr_val      out  32  old CSR value to rd
//  csr_illegal  out  1   access is illegal; core raises an illegal-instruction trap
//  instret_inc  in   1   one instruction retired this cycle
//  trap_valid   in   1   take a trap this cycle
//  trap_cause   in   32  mcause value
//  trap_pc      in   32  faulting PC -> mepc
//  trap_tval    in   32  -> mtval
//  mret         in   1   MRET retires this cycle
//  mtvec_o      out  32  trap vector base (direct mode)
//  mepc_o       out  32  return PC for MRET
//  mstatus_mie  out  1   global interrupt enable
// BEHAVIOUR
//  Reset: all CSRs 0 except mstatus.MPP=2'b11 (hardwired); csr_val=0, csr_illegal=0, outputs reflect 0.
//  Read: combinational, same cycle. csr_val = (csr_valid & csr_ren & !csr_illegal) ? old : 0.
//  Source: src = opcode[2] ? {27'b0,uimm} : reg_val. RW: new=src; RS: old|src; RC: old&~src.
//  Write: committed at next posedge when csr_valid & csr_wen & !csr_illegal & !trap_valid.
//  Map: mstatus 300 (MIE[3], MPIE[7] writable, rest 0), misa 301 RO, mie 304, mtvec 305 ([1:0] forced 0),
//    mscratch 340, mepc 341 ([1:0] forced 0), mcause 342, mtval 343, mip 344 reads 0, writes ignored,
//    mcycle/h B00/B80, minstret/h B02/B82, cycle/h C00/C80 and instret/h C02/C82 RO shadows, mhartid F14.
//  Illegal: csr_valid & (unmapped index, or csr_wen & index[11:10]==2'b11). No state change; csr_val=0.
//  mcycle: +1 every cycle, 64-bit wrap. minstret: +1 when instret_inc, 64-bit wrap.
//  Counter write: written half takes src, other half holds, no increment that cycle (write wins).
//  Trap: mepc<=trap_pc&~3, mcause<=trap_cause, mtval<=trap_tval, MPIE<=MIE, MIE<=0; suppresses same-cycle CSR write.
//  MRET: MIE<=MPIE, MPIE<=1. trap_valid & mret together: trap wins, mret ignored.
//  Counters still advance during trap/mret cycles. rst mid-stream: everything reverts to reset values.
// STRUCTURE
//  rv32ima_pkg additions: csr_addr_t enum of the indices above; MSTATUS_MIE=3, MSTATUS_MPIE=7 bit constants;
//    CSR opcode encodings (RW=001,RS=010,RC=011,RWI=101,RSI=110,RCI=111) if not already present.
//  Sub-module csr_counter64: 64-bit counter; inc, wr_lo, wr_hi, wdata; write overrides increment.
//  csr_file holds two csr_counter64 instances plus the read mux, illegal decode and write logic.
// TESTING
//  1 Reset then CSRRW mscratch src=0xDEADBEEF, read back via CSRRS rs1=0 -> first csr_val=0, then 0xDEADBEEF.
//  2 mscratch=0xF0F0; CSRRSI uimm=5 -> returns 0xF0F0, becomes 0xF0F5; CSRRCI uimm=0x10 -> 0xF0E5.
//  3 CSRRW to mhartid (F14) or unmapped 0x7C0 -> csr_illegal=1, csr_val=0, state unchanged.
//  4 Write mcycle=0xFFFFFFFF, mcycleh=0 -> read mcycleh 0 then 1 after wrap; write cycle stalls +1 that cycle only.
//  5 MIE=1, trap_valid cause=2 pc=0x103 tval=0xBAD with concurrent mscratch write -> mepc=0x100, mcause=2,
//    mtval=0xBAD, MIE=0, MPIE=1, mscratch unchanged; then mret -> MIE=1, MPIE=1.
//  6 instret_inc held 10 cycles, rst asserted mid-run -> minstret counts 1..n, then 0 after rst.

Source files
------------

// File: rtl/csr_file_pkg.sv
// Shared types for the machine-mode CSR file: CSR index map, SYSTEM funct3
// encodings, mstatus bit positions and the read-modify-write helper.
package csr_file_pkg;

    typedef enum logic [2:0] {
        FnPriv   = 3'b000,
        FnCsrrw  = 3'b001,
        FnCsrrs  = 3'b010,
        FnCsrrc  = 3'b011,
        FnRsvd   = 3'b100,
        FnCsrrwi = 3'b101,
        FnCsrrsi = 3'b110,
        FnCsrrci = 3'b111
    } system_funct3_t;

    typedef enum logic [11:0] {
        CsrMstatus   = 12'h300,
        CsrMisa      = 12'h301,
        CsrMie       = 12'h304,
        CsrMtvec     = 12'h305,
        CsrMscratch  = 12'h340,
        CsrMepc      = 12'h341,
        CsrMcause    = 12'h342,
        CsrMtval     = 12'h343,
        CsrMip       = 12'h344,
        CsrMcycle    = 12'hB00,
        CsrMinstret  = 12'hB02,
        CsrMcycleh   = 12'hB80,
        CsrMinstreth = 12'hB82,
        CsrCycle     = 12'hC00,
        CsrInstret   = 12'hC02,
        CsrCycleh    = 12'hC80,
        CsrInstreth  = 12'hC82,
        CsrMhartid   = 12'hF14
    } csr_addr_t;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam logic [1:0]  MSTATUS_MPP_M = 2'b11;

    // funct3[1:0] selects the operation; funct3[2] only selects the source.
    function automatic logic [31:0] csr_apply(input logic [2:0] op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] src);
        logic [31:0] res;
        res = old_val;
        case (op[1:0])
            2'b01:   res = src;
            2'b10:   res = old_val | src;
            2'b11:   res = old_val & ~src;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_file_if.sv
// CSR access channel between decode/execute (master) and the CSR file (slave).
interface csr_if;
    logic [11:0] csr_index;
    logic [2:0]  csr_opcode;
    logic        csr_valid;
    logic        csr_ren;
    logic        csr_wen;
    logic [31:0] csr_reg_val;
    logic [4:0]  csr_uimm;
    logic [31:0] csr_val;
    logic        csr_illegal;

    modport master (
        output csr_index, csr_opcode, csr_valid, csr_ren, csr_wen, csr_reg_val, csr_uimm,
        input  csr_val, csr_illegal
    );

    modport slave (
        input  csr_index, csr_opcode, csr_valid, csr_ren, csr_wen, csr_reg_val, csr_uimm,
        output csr_val, csr_illegal
    );
endinterface

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// Any write in a cycle suppresses that cycle's increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [63:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (wr_lo || wr_hi) begin
            value_d[31:0]  = wr_lo ? wdata : value_q[31:0];
            value_d[63:32] = wr_hi ? wdata : value_q[63:32];
        end else if (inc) begin
            value_d = value_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: read-old/write-new CSR access, trap/MRET state
// and the cycle/instret counters; exports mtvec/mepc/MIE to the pipeline.
module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [31:0] HART_ID  = 32'd0,
    parameter logic [31:0] MISA_VAL = 32'h40001101
) (
    input  logic        clk,
    input  logic        rst,
    csr_if.slave        csr,
    input  logic        instret_inc,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mstatus_mie
);

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_csr_q, mie_csr_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;

    logic [63:0] mcycle, minstret;
    logic [31:0] mstatus_rd;
    logic [31:0] old_val;
    logic [31:0] src;
    logic [31:0] wdata;
    logic        mapped;
    logic        illegal;
    logic        wr_en;

    always_comb begin
        mstatus_rd                = '0;
        mstatus_rd[12:11]         = MSTATUS_MPP_M;
        mstatus_rd[MSTATUS_MPIE]  = mstatus_mpie_q;
        mstatus_rd[MSTATUS_MIE]   = mstatus_mie_q;
    end

    // Read mux and address decode; unlisted indices are unmapped.
    always_comb begin
        mapped  = 1'b1;
        old_val = '0;
        case (csr.csr_index)
            CsrMstatus:                old_val = mstatus_rd;
            CsrMisa:                   old_val = MISA_VAL;
            CsrMie:                    old_val = mie_csr_q;
            CsrMtvec:                  old_val = mtvec_q;
            CsrMscratch:               old_val = mscratch_q;
            CsrMepc:                   old_val = mepc_q;
            CsrMcause:                 old_val = mcause_q;
            CsrMtval:                  old_val = mtval_q;
            CsrMip:                    old_val = '0;
            CsrMcycle, CsrCycle:       old_val = mcycle[31:0];
            CsrMcycleh, CsrCycleh:     old_val = mcycle[63:32];
            CsrMinstret, CsrInstret:   old_val = minstret[31:0];
            CsrMinstreth, CsrInstreth: old_val = minstret[63:32];
            CsrMhartid:                old_val = HART_ID;
            default:                   mapped  = 1'b0;
        endcase
    end

    // index[11:10] == 2'b11 marks the read-only CSR space.
    assign illegal = csr.csr_valid &
                     (~mapped | (csr.csr_wen & (csr.csr_index[11:10] == 2'b11)));
    assign src     = csr.csr_opcode[2] ? {27'b0, csr.csr_uimm} : csr.csr_reg_val;
    assign wdata   = csr_apply(csr.csr_opcode, old_val, src);
    assign wr_en   = csr.csr_valid & csr.csr_wen & ~illegal & ~trap_valid;

    assign csr.csr_val     = (csr.csr_valid & csr.csr_ren & ~illegal) ? old_val : '0;
    assign csr.csr_illegal = illegal;

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_csr_d      = mie_csr_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;

        if (wr_en) begin
            case (csr.csr_index)
                CsrMstatus: begin
                    mstatus_mie_d  = wdata[MSTATUS_MIE];
                    mstatus_mpie_d = wdata[MSTATUS_MPIE];
                end
                CsrMie:      mie_csr_d  = wdata;
                CsrMtvec:    mtvec_d    = {wdata[31:2], 2'b00};
                CsrMscratch: mscratch_d = wdata;
                CsrMepc:     mepc_d     = {wdata[31:2], 2'b00};
                CsrMcause:   mcause_d   = wdata;
                CsrMtval:    mtval_d    = wdata;
                default:     ;
            endcase
        end

        // Trap outranks MRET; MRET outranks a same-cycle mstatus write.
        if (trap_valid) begin
            mepc_d         = {trap_pc[31:2], 2'b00};
            mcause_d       = trap_cause;
            mtval_d        = trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_csr_q      <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_csr_q      <= mie_csr_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (wr_en & (csr.csr_index == CsrMcycle)),
        .wr_hi (wr_en & (csr.csr_index == CsrMcycleh)),
        .wdata (wdata),
        .value (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instret_inc),
        .wr_lo (wr_en & (csr.csr_index == CsrMinstret)),
        .wr_hi (wr_en & (csr.csr_index == CsrMinstreth)),
        .wdata (wdata),
        .value (minstret)
    );

    assign mtvec_o     = mtvec_q;
    assign mepc_o      = mepc_q;
    assign mstatus_mie = mstatus_mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: expected read data and illegal flags are
// queued when each access is driven and compared when the DUT responds.
module tb_csr_file;
    import csr_file_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instret_inc;
    logic        trap_valid;
    logic [31:0] trap_cause, trap_pc, trap_tval;
    logic        mret;
    logic [31:0] mtvec_o, mepc_o;
    logic        mstatus_mie;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_val_q[$];
    logic        exp_ill_q[$];

    csr_if bus ();

    csr_file #(
        .HART_ID  (32'd0),
        .MISA_VAL (32'h40001101)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr         (bus),
        .instret_inc (instret_inc),
        .trap_valid  (trap_valid),
        .trap_cause  (trap_cause),
        .trap_pc     (trap_pc),
        .trap_tval   (trap_tval),
        .mret        (mret),
        .mtvec_o     (mtvec_o),
        .mepc_o      (mepc_o),
        .mstatus_mie (mstatus_mie)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Tasks start just after a negedge and return just after the next one.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.csr_valid = 1'b0;
        bus.csr_ren   = 1'b0;
        bus.csr_wen   = 1'b0;
        step();
    endtask

    task automatic csr_op(input string tag, input logic [11:0] idx, input logic [2:0] opc,
                          input logic [31:0] src, input logic ren, input logic wen,
                          input logic [31:0] exp_val, input logic exp_ill);
        bus.csr_valid  = 1'b1;
        bus.csr_index  = idx;
        bus.csr_opcode = opc;
        bus.csr_ren    = ren;
        bus.csr_wen    = wen;
        if (opc[2]) begin
            bus.csr_uimm    = src[4:0];
            bus.csr_reg_val = $urandom;
        end else begin
            bus.csr_reg_val = src;
            bus.csr_uimm    = 5'($urandom);
        end
        exp_val_q.push_back(exp_val);
        exp_ill_q.push_back(exp_ill);
        #1;
        check_eq({tag, ".val"}, bus.csr_val, exp_val_q.pop_front());
        check_eq({tag, ".ill"}, 32'(bus.csr_illegal), 32'(exp_ill_q.pop_front()));
        step();
    endtask

    task automatic rd(input string tag, input logic [11:0] idx, input logic [31:0] exp_val);
        csr_op(tag, idx, FnCsrrs, 32'd0, 1'b1, 1'b0, exp_val, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        instret_inc = 1'b0;
        trap_valid = 1'b0;
        trap_cause = '0;
        trap_pc = '0;
        trap_tval = '0;
        mret = 1'b0;
        bus.csr_valid = 1'b0;
        bus.csr_index = '0;
        bus.csr_opcode = '0;
        bus.csr_ren = 1'b0;
        bus.csr_wen = 1'b0;
        bus.csr_reg_val = '0;
        bus.csr_uimm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        check_eq("rst.mtvec", mtvec_o, 32'h0);
        check_eq("rst.mepc", mepc_o, 32'h0);
        check_eq("rst.mie", 32'(mstatus_mie), 32'h0);
        check_eq("rst.val", bus.csr_val, 32'h0);
        check_eq("rst.ill", 32'(bus.csr_illegal), 32'h0);
        rd("rst.mstatus", CsrMstatus, 32'h0000_1800);
        rd("rst.mscratch", CsrMscratch, 32'h0);

        // Read-old/write-new on mscratch
        csr_op("t1.wr", CsrMscratch, FnCsrrw, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0, 1'b0);
        rd("t1.rd", CsrMscratch, 32'hDEADBEEF);

        // Immediate set/clear
        csr_op("t2.wr", CsrMscratch, FnCsrrw, 32'h0000_F0F0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        csr_op("t2.rsi", CsrMscratch, FnCsrrsi, 32'd5, 1'b1, 1'b1, 32'h0000_F0F0, 1'b0);
        csr_op("t2.rci", CsrMscratch, FnCsrrci, 32'h10, 1'b1, 1'b1, 32'h0000_F0F5, 1'b0);
        rd("t2.rd", CsrMscratch, 32'h0000_F0E5);

        // Illegal accesses and WARL/read-only registers
        csr_op("t3.hartid_wr", CsrMhartid, FnCsrrw, 32'h1, 1'b1, 1'b1, 32'h0, 1'b1);
        csr_op("t3.unmapped_wr", 12'h7C0, FnCsrrw, 32'h1, 1'b1, 1'b1, 32'h0, 1'b1);
        csr_op("t3.unmapped_rd", 12'h7C0, FnCsrrs, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        csr_op("t3.cycle_wr", CsrCycle, FnCsrrw, 32'h55, 1'b1, 1'b1, 32'h0, 1'b1);
        rd("t3.hartid_rd", CsrMhartid, 32'h0);
        rd("t3.mscratch", CsrMscratch, 32'h0000_F0E5);
        csr_op("t3.misa_wr", CsrMisa, FnCsrrw, 32'h0, 1'b1, 1'b1, 32'h40001101, 1'b0);
        rd("t3.misa_rd", CsrMisa, 32'h40001101);
        csr_op("t3.mtvec_wr", CsrMtvec, FnCsrrw, 32'h0000_1003, 1'b1, 1'b1, 32'h0, 1'b0);
        check_eq("t3.mtvec_o", mtvec_o, 32'h0000_1000);
        csr_op("t3.mip_wr", CsrMip, FnCsrrw, 32'hFFFF, 1'b1, 1'b1, 32'h0, 1'b0);
        rd("t3.mip_rd", CsrMip, 32'h0);

        // Counter write wins over increment; carry into the high half
        csr_op("t4.wlo", CsrMcycle, FnCsrrw, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 1'b0);
        csr_op("t4.whi", CsrMcycleh, FnCsrrw, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0);
        rd("t4.lo_held", CsrMcycle, 32'hFFFF_FFFF);
        rd("t4.hi_wrap", CsrMcycleh, 32'h1);
        rd("t4.cycle", CsrCycle, 32'h1);
        rd("t4.cycleh", CsrCycleh, 32'h1);

        // Trap with concurrent CSR write, then MRET
        csr_op("t5.setmie", CsrMstatus, FnCsrrsi, 32'h8, 1'b1, 1'b1, 32'h0000_1800, 1'b0);
        check_eq("t5.mie_on", 32'(mstatus_mie), 32'h1);
        trap_valid = 1'b1;
        trap_cause = 32'd2;
        trap_pc    = 32'h0000_0103;
        trap_tval  = 32'h0000_0BAD;
        csr_op("t5.trapwr", CsrMscratch, FnCsrrw, 32'h1234_5678, 1'b1, 1'b1,
               32'h0000_F0E5, 1'b0);
        trap_valid = 1'b0;
        check_eq("t5.mepc_o", mepc_o, 32'h0000_0100);
        check_eq("t5.mie_off", 32'(mstatus_mie), 32'h0);
        rd("t5.mepc", CsrMepc, 32'h0000_0100);
        rd("t5.mcause", CsrMcause, 32'h2);
        rd("t5.mtval", CsrMtval, 32'h0000_0BAD);
        rd("t5.mstatus", CsrMstatus, 32'h0000_1880);
        rd("t5.mscratch", CsrMscratch, 32'h0000_F0E5);
        mret = 1'b1;
        idle();
        mret = 1'b0;
        check_eq("t5.mret_mie", 32'(mstatus_mie), 32'h1);
        rd("t5.mret_mstatus", CsrMstatus, 32'h0000_1888);
        trap_valid = 1'b1;
        mret       = 1'b1;
        trap_cause = 32'd3;
        trap_pc    = 32'h0000_0200;
        trap_tval  = 32'h0;
        idle();
        trap_valid = 1'b0;
        mret       = 1'b0;
        check_eq("t5.both_mie", 32'(mstatus_mie), 32'h0);
        check_eq("t5.both_mepc", mepc_o, 32'h0000_0200);
        rd("t5.both_mstatus", CsrMstatus, 32'h0000_1880);

        // instret counting and mid-stream reset
        rd("t6.inst0", CsrMinstret, 32'h0);
        instret_inc = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            rd($sformatf("t6.inst%0d", i), CsrMinstret, 32'(i));
        end
        bus.csr_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        instret_inc = 1'b0;
        rd("t6.mcycle_rst", CsrMcycle, 32'h0);
        rd("t6.minstret_rst", CsrMinstret, 32'h0);
        rd("t6.minstreth_rst", CsrMinstreth, 32'h0);
        rd("t6.mscratch_rst", CsrMscratch, 32'h0);
        rd("t6.mstatus_rst", CsrMstatus, 32'h0000_1800);
        check_eq("t6.mepc_rst", mepc_o, 32'h0);
        check_eq("t6.mtvec_rst", mtvec_o, 32'h0);

        idle();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
